// File: rtl/seq101_tx.sv
// Serial frame transmitter: on accept, sends a fixed preamble, then the data word,
// then a forced zero gap on a single registered line.
module seq101_tx #(
  parameter int unsigned      DATA_W    = 8,
  parameter int unsigned      PRE_W     = 3,
  parameter logic [PRE_W-1:0] PREAMBLE  = 3'b101,
  parameter int unsigned      GAP       = 2,
  parameter bit               MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              sel,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned MAX_PD = (PRE_W > DATA_W) ? PRE_W : DATA_W;
  localparam int unsigned MAX_V  = (MAX_PD > GAP) ? MAX_PD : GAP;
  localparam int unsigned CW     = $clog2(MAX_V + 1);

  localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_W);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_GAP} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic              sel_q, sel_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [CW-1:0]     cnt_inc;
  logic              data_bit;
  logic [DATA_W-1:0] shift_nxt;

  // cnt counts bits already placed on sel in the current state, starting at 1 on entry.
  assign cnt_inc   = cnt_q + CW'(1);
  assign data_bit  = MSB_FIRST ? shift_q[DATA_W-1] : shift_q[0];
  assign shift_nxt = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);

  always_comb begin
    // NOTE: every next-state variable gets a default first so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    pre_d   = pre_q;
    sel_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_PRE;
          cnt_d   = CW'(1);
          shift_d = in_data;
          sel_d   = PREAMBLE[PRE_W-1];
          pre_d   = PREAMBLE << 1;
        end
      end
      S_PRE: begin
        if (cnt_q == PRE_LAST) begin
          state_d = S_DATA;
          cnt_d   = CW'(1);
          sel_d   = data_bit;
          shift_d = shift_nxt;
          done_d  = (DATA_W == 1);
        end else begin
          sel_d = pre_q[PRE_W-1];
          pre_d = pre_q << 1;
          cnt_d = cnt_inc;
        end
      end
      S_DATA: begin
        if (cnt_q == DATA_LAST) begin
          if (GAP > 0) begin
            state_d = S_GAP;
            cnt_d   = CW'(1);
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end else begin
          sel_d   = data_bit;
          shift_d = shift_nxt;
          cnt_d   = cnt_inc;
          done_d  = (cnt_inc == DATA_LAST);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      pre_q   <= '0;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      pre_q   <= pre_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign sel        = sel_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule
